// File: rtl/pulse_pkg.sv
// Shared constants, opcode table and FSM state type for the pulse generator
// configuration controller.
package pulse_pkg;

   localparam int ED_BITS    = 68;
   localparam int COUNT_BITS = 32;
   localparam int CH_LOG2    = 3;
   localparam int ASM_BYTES  = 10;

   localparam logic [7:0] OP_WR_EDGE   = 8'h01;
   localparam logic [7:0] OP_WR_PERIOD = 8'h02;
   localparam logic [7:0] OP_WR_OUTER  = 8'h03;
   localparam logic [7:0] OP_WR_STATE0 = 8'h04;
   localparam logic [7:0] OP_COMMIT    = 8'h05;
   localparam logic [7:0] OP_CLEAR     = 8'h06;
   localparam logic [7:0] OP_RUN       = 8'h07;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OPCODE  = 2'd1;
   localparam logic [1:0] ERR_INDEX   = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PAYLOAD,
      S_EXEC,
      S_COMMIT_WAIT,
      S_SWAP
   } state_e;

   function automatic logic op_valid(input logic [7:0] op);
      return (op >= OP_WR_EDGE) && (op <= OP_RUN);
   endfunction

   // Payload byte count that follows each opcode.
   function automatic logic [3:0] op_len(input logic [7:0] op);
      case (op)
         OP_WR_EDGE:                 return 4'd10;
         OP_WR_PERIOD, OP_WR_OUTER:  return 4'd4;
         OP_WR_STATE0, OP_RUN:       return 4'd1;
         default:                    return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/cfg_byte_assembler.sv
// Payload assembler: MSB-first shift register, remaining-byte counter and
// inter-byte idle timeout.
module cfg_byte_assembler
   import pulse_pkg::*;
#(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     load_i,
   input  logic [3:0]               len_i,
   input  logic                     active_i,
   input  logic                     byte_vld_i,
   input  logic [7:0]               byte_i,
   output logic [8*ASM_BYTES-1:0]   word_o,
   output logic                     done_o,
   output logic                     timeout_o
);

   localparam int          ASM_W    = 8 * ASM_BYTES;
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   logic [ASM_W-1:0] shreg_q, shreg_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [31:0]      tmo_q, tmo_d;

   always_comb begin
      shreg_d   = byte_vld_i ? {shreg_q[ASM_W-9:0], byte_i} : shreg_q;
      cnt_d     = cnt_q;
      tmo_d     = '0;
      done_o    = active_i && byte_vld_i && (cnt_q == 4'd1);
      timeout_o = active_i && !byte_vld_i && (tmo_q == TMO_LAST);
      if (load_i) begin
         cnt_d = len_i;
      end else if (active_i && byte_vld_i) begin
         cnt_d = cnt_q - 4'd1;
      end else if (active_i && !timeout_o) begin
         tmo_d = tmo_q + 32'd1;
      end
      if (timeout_o) begin
         cnt_d = '0;
      end
   end

   // Assembled data needs no reset; only the counters are control state.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tmo_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign word_o = shreg_q;

endmodule

// File: rtl/pulse_cfg_ctrl.sv
// Byte-stream configuration sequencer: builds a shadow copy of the generator
// settings and swaps it into the active registers at a frame boundary.
module pulse_cfg_ctrl
   import pulse_pkg::*;
#(
   parameter int ED_MAX  = 255,
   parameter int ED_BITS = 68,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [7:0]                in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      frame_end,
   output logic [COUNT_BITS-1:0]     period,
   output logic [COUNT_BITS-1:0]     outer_period,
   output logic [7:0]                state0,
   output logic [ED_BITS*ED_MAX-1:0] eds,
   output logic                      gen_reset,
   output logic                      running,
   output logic                      busy,
   output logic                      err,
   output logic [1:0]                err_code
);

   localparam int ASM_W  = 8 * ASM_BYTES;
   localparam int EDGE_W = 1 + CH_LOG2 + 2 * COUNT_BITS;

   state_e                 state_q, state_d;
   logic [7:0]             op_q;
   logic                   running_q, running_d;
   logic                   gen_reset_q, in_ready_q, busy_q, err_q;
   logic [1:0]             err_code_q;
   logic [COUNT_BITS-1:0]  shd_period_q, shd_outer_q, act_period_q, act_outer_q;
   logic [7:0]             shd_state0_q, act_state0_q;
   logic [ED_BITS-1:0]     shd_eds_q [ED_MAX];
   logic [ED_BITS-1:0]     act_eds_q [ED_MAX];

   logic                   byte_acc, asm_load, asm_done, asm_timeout;
   logic [ASM_W-1:0]       asm_word;
   logic [7:0]             edge_idx;
   logic                   unused_nibble;

   assign byte_acc = in_valid && in_ready_q;
   assign asm_load = byte_acc && (state_q == S_IDLE) && op_valid(in_data)
                     && (op_len(in_data) != 4'd0);
   assign edge_idx = asm_word[ASM_W-1 -: 8];
   // The top nibble of the first edge byte carries no information.
   assign unused_nibble = ^asm_word[ASM_W-9:EDGE_W];

   cfg_byte_assembler #(
      .TIMEOUT (TIMEOUT)
   ) u_asm (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (asm_load),
      .len_i      (op_len(in_data)),
      .active_i   (state_q == S_PAYLOAD),
      .byte_vld_i (byte_acc),
      .byte_i     (in_data),
      .word_o     (asm_word),
      .done_o     (asm_done),
      .timeout_o  (asm_timeout)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:
            if (byte_acc && op_valid(in_data)) begin
               state_d = (op_len(in_data) == 4'd0) ? S_EXEC : S_PAYLOAD;
            end
         S_PAYLOAD:
            if (asm_timeout)   state_d = S_IDLE;
            else if (asm_done) state_d = S_EXEC;
         S_EXEC:
            state_d = (op_q == OP_COMMIT) ? S_COMMIT_WAIT : S_IDLE;
         S_COMMIT_WAIT:
            if (!running_q || frame_end) state_d = S_SWAP;
         S_SWAP:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   assign running_d = (state_q == S_EXEC && op_q == OP_RUN) ? asm_word[0] : running_q;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         op_q         <= '0;
         running_q    <= 1'b0;
         gen_reset_q  <= 1'b1;
         in_ready_q   <= 1'b1;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         shd_period_q <= '0;
         shd_outer_q  <= '0;
         shd_state0_q <= '0;
         act_period_q <= '0;
         act_outer_q  <= '0;
         act_state0_q <= '0;
         for (int i = 0; i < ED_MAX; i++) begin
            shd_eds_q[i] <= '0;
            act_eds_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         running_q   <= running_d;
         in_ready_q  <= (state_d == S_IDLE) || (state_d == S_PAYLOAD);
         busy_q      <= (state_d != S_IDLE);
         // Generator held in reset while stopped, and across the swap cycle plus one.
         gen_reset_q <= !running_d || (state_d == S_SWAP) || (state_q == S_SWAP);
         err_q       <= 1'b0;

         if (state_q == S_IDLE && byte_acc) begin
            op_q <= in_data;
            if (!op_valid(in_data)) begin
               err_q      <= 1'b1;
               err_code_q <= ERR_OPCODE;
            end
         end

         if (state_q == S_PAYLOAD && asm_timeout) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
         end

         if (state_q == S_EXEC) begin
            case (op_q)
               OP_WR_EDGE:
                  if (int'(edge_idx) >= ED_MAX) begin
                     err_q      <= 1'b1;
                     err_code_q <= ERR_INDEX;
                  end else begin
                     shd_eds_q[edge_idx] <= asm_word[EDGE_W-1:0];
                  end
               OP_WR_PERIOD: shd_period_q <= asm_word[COUNT_BITS-1:0];
               OP_WR_OUTER:  shd_outer_q  <= asm_word[COUNT_BITS-1:0];
               OP_WR_STATE0: shd_state0_q <= asm_word[7:0];
               OP_CLEAR:
                  for (int i = 0; i < ED_MAX; i++) begin
                     shd_eds_q[i] <= '0;
                  end
               default: ;
            endcase
         end

         if (state_q == S_SWAP) begin
            act_period_q <= shd_period_q;
            act_outer_q  <= shd_outer_q;
            act_state0_q <= shd_state0_q;
            act_eds_q    <= shd_eds_q;
         end
      end
   end

   for (genvar g = 0; g < ED_MAX; g++) begin : g_eds
      assign eds[g*ED_BITS +: ED_BITS] = act_eds_q[g];
   end

   assign in_ready     = in_ready_q;
   assign period       = act_period_q;
   assign outer_period = act_outer_q;
   assign state0       = act_state0_q;
   assign gen_reset    = gen_reset_q;
   assign running      = running_q;
   assign busy         = busy_q;
   assign err          = err_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_pulse_cfg_ctrl.sv
// Self-checking bench for pulse_cfg_ctrl: command table, commit scoreboard and
// hand-built sequences for the multi-cycle corner cases.
module tb_pulse_cfg_ctrl;

   localparam int EDM = 255;
   localparam int EB  = 68;
   localparam int TMO = 40;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              frame_end = 1'b0;
   logic              in_ready, gen_reset, running, busy, err;
   logic [31:0]       period, outer_period;
   logic [7:0]        state0;
   logic [EB*EDM-1:0] eds;
   logic [1:0]        err_code;

   pulse_cfg_ctrl #(.ED_MAX(EDM), .ED_BITS(EB), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .frame_end(frame_end), .period(period),
      .outer_period(outer_period), .state0(state0), .eds(eds),
      .gen_reset(gen_reset), .running(running), .busy(busy), .err(err),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int err_total = 0;
   int lowrun = 0;

   typedef struct {
      logic [31:0]       p;
      logic [31:0]       o;
      logic [7:0]        s0;
      logic [EB*EDM-1:0] e;
   } snap_t;
   snap_t sb_q[$];

   typedef struct packed {
      logic [87:0] b;
      logic [3:0]  n;
      logic [3:0]  errs;
      logic [1:0]  code;
      logic        busy1;
   } vec_t;
   vec_t vec [10];

   logic [31:0]   m_period, m_outer;
   logic [7:0]    m_state0;
   logic [EB-1:0] m_eds [EDM];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_pop();
      snap_t s;
      tests++;
      if (sb_q.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected_swap: got an active update with 0 expected entries queued");
         return;
      end
      s = sb_q.pop_front();
      check("sb_period", period, s.p);
      check("sb_outer", outer_period, s.o);
      check("sb_state0", state0, s.s0);
      if (eds !== s.e) begin
         int bad;
         bad = 0;
         for (int i = EDM - 1; i >= 0; i--) if (eds[i*EB +: EB] !== s.e[i*EB +: EB]) bad = i;
         fails++;
         $display("FAIL sb_eds slot %0d: got 0x%0h expected 0x%0h",
                  bad, eds[bad*EB +: EB], s.e[bad*EB +: EB]);
      end
   endtask

   // Every cycle of the bench goes through here so the monitor sees all of them.
   task automatic tick();
      @(negedge clk);
      if (err) err_total++;
      if (!reset_n) lowrun = 0;
      else if (!in_ready) lowrun++;
      else begin
         if (lowrun >= 3) sb_pop();
         lowrun = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int w;
      w = 0;
      tick();
      while (!in_ready && w < 200) begin
         tick();
         w++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_byte_ready: in_ready=%0b required 1", in_ready);
         return;
      end
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic model_reset();
      m_period = '0;
      m_outer  = '0;
      m_state0 = '0;
      for (int i = 0; i < EDM; i++) m_eds[i] = '0;
   endtask

   task automatic model_apply(input logic [87:0] r);
      case (r[87:80])
         8'h01: if (r[79:72] < EDM) m_eds[r[79:72]] = r[67:0];
         8'h02: m_period = r[79:48];
         8'h03: m_outer  = r[79:48];
         8'h04: m_state0 = r[79:72];
         8'h06: for (int i = 0; i < EDM; i++) m_eds[i] = '0;
         default: ;
      endcase
   endtask

   task automatic send_cmd(input logic [87:0] r, input int n);
      logic [87:0] t;
      for (int k = 0; k < n; k++) begin
         t = r << (8 * k);
         send_byte(t[87:80]);
      end
      model_apply(r);
   endtask

   task automatic send_commit(input bit push);
      snap_t s;
      if (push) begin
         s.p  = m_period;
         s.o  = m_outer;
         s.s0 = m_state0;
         for (int i = 0; i < EDM; i++) s.e[i*EB +: EB] = m_eds[i];
         sb_q.push_back(s);
      end
      send_byte(8'h05);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec[0] = '{b:{8'h42, 80'h0},                           n:1,  errs:1, code:1, busy1:0};
      vec[1] = '{b:{8'h01, 8'hFF, 8'h0A, 32'd1, 32'd2},      n:11, errs:1, code:2, busy1:1};
      vec[2] = '{b:{8'h04, 8'h5A, 72'h0},                    n:2,  errs:0, code:2, busy1:1};
      vec[3] = '{b:{8'h03, 32'd300, 48'h0},                  n:5,  errs:0, code:2, busy1:1};
      vec[4] = '{b:{8'h00, 80'h0},                           n:1,  errs:1, code:1, busy1:0};
      vec[5] = '{b:{8'h06, 80'h0},                           n:1,  errs:0, code:1, busy1:1};
      vec[6] = '{b:{8'h01, 8'h07, 8'hF8, 32'd5, 32'd9},      n:11, errs:0, code:1, busy1:1};
      vec[7] = '{b:{8'h01, 8'hFE, 8'h03, 32'd1, 32'd2},      n:11, errs:0, code:1, busy1:1};
      vec[8] = '{b:{8'h01, 8'h03, 8'h0A, 32'd1, 32'd2},      n:11, errs:0, code:1, busy1:1};
      vec[9] = '{b:{8'h08, 80'h0},                           n:1,  errs:1, code:1, busy1:0};

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      check("rst_period", period, 0);
      check("rst_outer", outer_period, 0);
      check("rst_state0", state0, 0);
      check("rst_eds_any", {63'b0, |eds}, 0);
      check("rst_running", running, 0);
      check("rst_gen_reset", gen_reset, 1);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);

      // WR_PERIOD 1000 then COMMIT while stopped: three-cycle latency
      send_cmd({8'h02, 32'd1000, 48'h0}, 5);
      send_commit(1);
      tick(); check("c0_gen_reset_exec", gen_reset, 1);
      tick(); check("c0_gen_reset_wait", gen_reset, 1);
      tick(); check("c0_period_in_swap", period, 0);
      check("c0_gen_reset_swap", gen_reset, 1);
      tick(); check("c0_period_after_swap", period, 1000);
      check("c0_gen_reset_after", gen_reset, 1);

      // Command table
      for (int i = 0; i < 10; i++) begin
         int e0;
         e0 = err_total;
         send_cmd(vec[i].b, int'(vec[i].n));
         tick();
         check($sformatf("vec%0d_busy_next", i), busy, vec[i].busy1);
         repeat (3) tick();
         check($sformatf("vec%0d_err_pulses", i), err_total - e0, vec[i].errs);
         check($sformatf("vec%0d_err_code", i), err_code, vec[i].code);
         check($sformatf("vec%0d_idle_busy", i), busy, 0);
         check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      end
      check("tbl_period_unchanged", period, 1000);
      check("tbl_outer_unchanged", outer_period, 0);
      send_commit(1);
      repeat (4) tick();

      // RUN 1
      send_cmd({8'h07, 8'h01, 72'h0}, 2);
      repeat (3) tick();
      check("run1_running", running, 1);
      check("run1_gen_reset", gen_reset, 0);

      // Edge slot 5 commit gated by frame_end; the frame_end entering the wait is ignored
      send_cmd({8'h01, 8'h05, 8'h0A, 32'd10, 32'd100}, 11);
      send_commit(1);
      frame_end = 1'b1;
      tick();
      @(posedge clk);
      #1 frame_end = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("fe_wait%0d_slot5", i), eds[5*EB +: EB], 68'h0);
         check($sformatf("fe_wait%0d_busy", i), busy, 1);
         check($sformatf("fe_wait%0d_gen_reset", i), gen_reset, 0);
      end
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      tick();
      check("fe_swap_slot5_old", eds[5*EB +: EB], 68'h0);
      check("fe_swap_gen_reset", gen_reset, 1);
      tick();
      check("fe_after_slot5", eds[5*EB +: EB], 68'hA_0000000A_00000064);
      check("fe_after_gen_reset", gen_reset, 1);
      tick();
      check("fe_end_gen_reset", gen_reset, 0);

      // RUN 0
      send_cmd({8'h07, 8'h00, 72'h0}, 2);
      repeat (2) tick();
      check("run0_running", running, 0);
      check("run0_gen_reset", gen_reset, 1);

      // Timeout after two payload bytes, then a clean WR_PERIOD 16
      begin
         int e0;
         e0 = err_total;
         send_byte(8'h02);
         send_byte(8'h00);
         send_byte(8'h00);
         repeat (TMO + 5) tick();
         check("tmo_err_pulses", err_total - e0, 1);
         check("tmo_err_code", err_code, 3);
         check("tmo_busy", busy, 0);
         check("tmo_period_kept", period, 1000);
      end
      send_cmd({8'h02, 32'd16, 48'h0}, 5);
      send_commit(1);
      repeat (4) tick();
      check("tmo_next_period", period, 16);

      // Reset while waiting for a frame boundary
      send_cmd({8'h07, 8'h01, 72'h0}, 2);
      send_cmd({8'h04, 8'h33, 72'h0}, 2);
      send_commit(0);
      repeat (3) tick();
      check("cw_busy", busy, 1);
      check("cw_in_ready", in_ready, 0);
      @(posedge clk);
      #1 reset_n = 1'b0;
      tick();
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_reset();
      tick();
      check("cwr_period", period, 0);
      check("cwr_state0", state0, 0);
      check("cwr_eds_any", {63'b0, |eds}, 0);
      check("cwr_running", running, 0);
      check("cwr_gen_reset", gen_reset, 1);
      check("cwr_busy", busy, 0);
      check("cwr_in_ready", in_ready, 1);
      check("cwr_err_code", err_code, 0);
      frame_end = 1'b1;
      @(posedge clk);
      #1 frame_end = 1'b0;
      repeat (4) tick();
      check("cwr_no_swap_state0", state0, 0);
      check("cwr_no_swap_busy", busy, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
